new_means_calc_block: RTL and testbench
=======================================

NEW_MEANS_CALC_BLOCK -- requirements
Module: new_means_calc_block

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- centroid_num, 8, number of centroids.
- cord_num, 7, coordinates per point.
- accum_cord_width, 22, accumulated sum width per coordinate.
- cordinate_width, 13, coordinate width.
- count_width, 10, points-per-centroid count width.
- dataWidth, 91, packed centroid width (cord_num*cordinate_width).
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, clock.
- rst_n, in, 1, async active-low reset.
- start, in, 1, controller pulse; begins a mean-calculation pass.
- accum_sel, out, 3, selects centroid whose sums/count are presented.
- accum_in, in, 154, 7 packed unsigned 22-bit sums for accum_sel; coordinate 1 in the LSBs.
- count_in, in, 10, unsigned point count for accum_sel.
- new_centroid_out, out, 91, 7 packed unsigned 13-bit means; coordinate 1 in the LSBs.
- cent_num, out, 3, index of the centroid on new_centroid_out.
- divide_by_0, out, 1, high when the emitted centroid had count 0.
- centroid_valid, out, 1, one-cycle strobe per emitted centroid; drives convergence_reg_en.
- busy, out, 1, high from start acceptance until done.
- done, out, 1, one-cycle pulse after the last centroid.

Function
REQ-004 The FSM SHALL have states IDLE, LOAD, DIVIDE, EMIT and FINISH.
REQ-005 IDLE SHALL go to LOAD on start=1, clearing centroid index k to 0.
REQ-006 In IDLE, start=0 SHALL hold IDLE.
REQ-007 In LOAD, accum_sel SHALL equal k, and accum_in/count_in SHALL be latched internally at the LOAD clock edge.
REQ-008 LOAD SHALL go to DIVIDE if count_in!=0, else directly to EMIT.
REQ-009 DIVIDE SHALL run 7 parallel restoring dividers, one quotient bit per cycle, exactly 22 cycles, then go to EMIT.
REQ-010 Each quotient SHALL be floor(sum/count), truncated to the low 13 bits; the remainder SHALL be discarded.
REQ-011 In EMIT, centroid_valid SHALL be 1 for one cycle with cent_num=k.
REQ-012 In EMIT, new_centroid_out SHALL hold the quotients, or all-zero with divide_by_0=1 when the latched count was 0.
REQ-013 From EMIT, k<7 SHALL go to LOAD with k+1; k==7 SHALL go to FINISH.
REQ-014 FINISH SHALL assert done for one cycle, then go to IDLE.
REQ-015 Per-centroid latency SHALL be 24 cycles (LOAD+22+EMIT), or 2 cycles for count 0.
REQ-016 A full pass SHALL be at most 8*24+1 = 193 cycles from start to done.
REQ-017 new_centroid_out, cent_num and divide_by_0 SHALL be registered and SHALL hold their last EMIT values until the next EMIT, including through IDLE.
REQ-018 busy SHALL be 1 in every state except IDLE.
REQ-019 start SHALL be ignored while busy=1.
REQ-020 start coinciding with done SHALL be ignored.
REQ-021 All arithmetic SHALL be unsigned.
REQ-022 The internal k counter SHALL not wrap past 7.

Reset
REQ-023 rst_n=0 SHALL, asynchronously and at any time including mid-DIVIDE, force IDLE, k=0, accum_sel=0, new_centroid_out=0, cent_num=0, divide_by_0=0, centroid_valid=0, busy=0, done=0, and clear the divider registers.
REQ-024 After rst_n releases, the block SHALL require a fresh start; no partial pass resumes.

Structure
REQ-025 Widths, centroid_num, cord_num and the state enumeration SHALL live in shared package kmeans_pkg.
REQ-026 One sub-module, mean_divider (22/10-bit restoring, load/busy/quotient), SHALL be instantiated 7 times.

Verification
REQ-027 Single pass: all counts=4, coordinate sums=400 -> eight centroid_valid strobes 24 cycles apart, each coordinate 100, cent_num 0..7, done at cycle 193.
REQ-028 Count 0: centroid 3 count=0 -> its EMIT arrives 2 cycles after its LOAD, divide_by_0=1, new_centroid_out=0; the other centroids are unaffected.
REQ-029 Truncation: sum=1000, count=3 -> 333; sum=4194303, count=1 -> 8191 (low 13 bits of the quotient).
REQ-030 Busy start: start pulse during centroid 5 DIVIDE -> ignored, pass completes unchanged, exactly one done.
REQ-031 Reset mid-operation: rst_n low during centroid 2 DIVIDE -> all outputs 0 immediately; next start restarts at cent_num=0.
REQ-032 Back-to-back passes: start in the cycle after done -> second pass identical to the first; outputs held between passes.

Source files
------------

// File: rtl/kmeans_pkg.sv
// Shared widths, counts and FSM state encoding for the k-means mean-calculation block.
package kmeans_pkg;

    localparam int CENTROID_NUM     = 8;
    localparam int CORD_NUM         = 7;
    localparam int ACCUM_CORD_WIDTH = 22;
    localparam int CORDINATE_WIDTH  = 13;
    localparam int COUNT_WIDTH      = 10;
    localparam int DATA_WIDTH       = CORD_NUM * CORDINATE_WIDTH;

    // FSM state encoding, kept as plain constants for compatibility with older code
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_DIVIDE = 3'd2;
    localparam logic [2:0] ST_EMIT   = 3'd3;
    localparam logic [2:0] ST_FINISH = 3'd4;

    // Index width that never collapses to zero bits
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mean_divider.sv
// Restoring unsigned divider: one quotient bit per clock, DVD_W steps per division.
// quotient_next exposes the value the quotient register takes at the coming edge,
// so the caller can capture the finished result on the same edge the last bit lands.
module mean_divider
    import kmeans_pkg::*;
#(
    parameter int DVD_W = ACCUM_CORD_WIDTH,
    parameter int DVS_W = COUNT_WIDTH,
    parameter int Q_W   = CORDINATE_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             busy,
    output logic             last_step,
    output logic [Q_W-1:0]   quotient_next
);

    localparam int CNT_W = $clog2(DVD_W + 1);

    logic [DVD_W-1:0] dvd_reg;
    logic [DVS_W-1:0] dvs_reg;
    logic [DVS_W-1:0] rem_reg;
    logic [DVD_W-1:0] quo_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic [DVS_W:0]   trial;
    logic             ge;
    logic [DVS_W-1:0] rem_step;
    logic [DVD_W-1:0] quo_step;

    // One restoring step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        trial    = {rem_reg, dvd_reg[DVD_W-1]};
        ge       = (trial >= {1'b0, dvs_reg});
        rem_step = ge ? DVS_W'(trial - {1'b0, dvs_reg}) : DVS_W'(trial);
        quo_step = {quo_reg[DVD_W-2:0], ge};
    end

    assign busy          = (cnt_reg != '0);
    assign last_step     = (cnt_reg == CNT_W'(1));
    assign quotient_next = quo_step[Q_W-1:0];

    // Operand capture on load, then iterate until the step counter empties
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_reg <= '0;
            dvs_reg <= '0;
            rem_reg <= '0;
            quo_reg <= '0;
            cnt_reg <= '0;
        end else if (load) begin
            dvd_reg <= dividend;
            dvs_reg <= divisor;
            rem_reg <= '0;
            quo_reg <= '0;
            cnt_reg <= CNT_W'(DVD_W);
        end else if (busy) begin
            dvd_reg <= {dvd_reg[DVD_W-2:0], 1'b0};
            rem_reg <= rem_step;
            quo_reg <= quo_step;
            cnt_reg <= cnt_reg - CNT_W'(1);
        end
    end

endmodule

// File: rtl/new_means_calc_block.sv
// Computes new centroid means: for each centroid, divides every accumulated coordinate
// sum by the centroid's point count (truncated to coordinate width) and emits the result.
module new_means_calc_block
    import kmeans_pkg::*;
#(
    parameter int centroid_num     = CENTROID_NUM,
    parameter int cord_num         = CORD_NUM,
    parameter int accum_cord_width = ACCUM_CORD_WIDTH,
    parameter int cordinate_width  = CORDINATE_WIDTH,
    parameter int count_width      = COUNT_WIDTH,
    parameter int dataWidth        = DATA_WIDTH
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   start,
    output logic [clog2_min1(centroid_num)-1:0]    accum_sel,
    input  logic [cord_num*accum_cord_width-1:0]   accum_in,
    input  logic [count_width-1:0]                 count_in,
    output logic [dataWidth-1:0]                   new_centroid_out,
    output logic [clog2_min1(centroid_num)-1:0]    cent_num,
    output logic                                   divide_by_0,
    output logic                                   centroid_valid,
    output logic                                   busy,
    output logic                                   done
);

    localparam int SEL_W = clog2_min1(centroid_num);
    localparam logic [SEL_W-1:0] K_LAST = SEL_W'(centroid_num - 1);

    logic [2:0]       state_reg;
    logic [2:0]       state_next;
    logic [SEL_W-1:0] k_reg;

    logic [dataWidth-1:0] mean_out_reg;
    logic [SEL_W-1:0]     cent_num_reg;
    logic                 div0_reg;

    logic                 div_load;
    logic                 div_exit;
    logic [cord_num-1:0]  div_busy;
    logic [cord_num-1:0]  div_last;
    logic [dataWidth-1:0] div_q_next;

    assign div_load = (state_reg == ST_LOAD);
    // All dividers run in lockstep; leave DIVIDE when every one is on its final step
    assign div_exit = &(div_busy & div_last);

    generate
        for (genvar gi = 0; gi < cord_num; gi++) begin : g_div
            mean_divider #(
                .DVD_W (accum_cord_width),
                .DVS_W (count_width),
                .Q_W   (cordinate_width)
            ) u_div (
                .clk           (clk),
                .rst_n         (rst_n),
                .load          (div_load),
                .dividend      (accum_in[gi*accum_cord_width +: accum_cord_width]),
                .divisor       (count_in),
                .busy          (div_busy[gi]),
                .last_step     (div_last[gi]),
                .quotient_next (div_q_next[gi*cordinate_width +: cordinate_width])
            );
        end
    endgenerate

    // Next-state decode; start is only honoured from IDLE
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (start) state_next = ST_LOAD;
            ST_LOAD:   state_next = (count_in != '0) ? ST_DIVIDE : ST_EMIT;
            ST_DIVIDE: if (div_exit) state_next = ST_EMIT;
            ST_EMIT:   state_next = (k_reg == K_LAST) ? ST_FINISH : ST_LOAD;
            ST_FINISH: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // State register and centroid index; k saturates at the last centroid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            k_reg     <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_IDLE && start)
                k_reg <= '0;
            else if (state_reg == ST_EMIT && k_reg != K_LAST)
                k_reg <= k_reg + SEL_W'(1);
        end
    end

    // Result registers, loaded on the edge that enters EMIT and held until the next one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mean_out_reg <= '0;
            cent_num_reg <= '0;
            div0_reg     <= 1'b0;
        end else if (state_reg == ST_LOAD && count_in == '0) begin
            mean_out_reg <= '0;
            cent_num_reg <= k_reg;
            div0_reg     <= 1'b1;
        end else if (state_reg == ST_DIVIDE && div_exit) begin
            mean_out_reg <= div_q_next;
            cent_num_reg <= k_reg;
            div0_reg     <= 1'b0;
        end
    end

    assign accum_sel        = k_reg;
    assign new_centroid_out = mean_out_reg;
    assign cent_num         = cent_num_reg;
    assign divide_by_0      = div0_reg;
    assign centroid_valid   = (state_reg == ST_EMIT);
    assign busy             = (state_reg != ST_IDLE);
    assign done             = (state_reg == ST_FINISH);

endmodule

// File: tb/tb_new_means_calc_block.sv
// Self-checking bench for new_means_calc_block: directed scenarios with random data,
// checked against a plain-arithmetic reference of sum/count per centroid.
module tb_new_means_calc_block;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [2:0]   accum_sel;
    logic [153:0] accum_in;
    logic [9:0]   count_in;
    logic [90:0]  new_centroid_out;
    logic [2:0]   cent_num;
    logic         divide_by_0;
    logic         centroid_valid;
    logic         busy;
    logic         done;

    int n_cmp;
    int n_fail;

    // Per-centroid stimulus presented through accum_sel
    int unsigned sums   [8][7];
    int unsigned counts [8];

    new_means_calc_block dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .accum_sel        (accum_sel),
        .accum_in         (accum_in),
        .count_in         (count_in),
        .new_centroid_out (new_centroid_out),
        .cent_num         (cent_num),
        .divide_by_0      (divide_by_0),
        .centroid_valid   (centroid_valid),
        .busy             (busy),
        .done             (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accumulator memory model: answers whatever centroid the block selects
    always_comb begin
        accum_in = '0;
        for (int c = 0; c < 7; c++)
            accum_in[c*22 +: 22] = sums[accum_sel][c][21:0];
        count_in = counts[accum_sel][9:0];
    end

    task automatic chk(input string tag, input logic [153:0] obs, input logic [153:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: floor(sum/count) kept to 13 bits, zero when count is zero
    function automatic logic [90:0] ref_mean(input int i);
        logic [90:0] m;
        m = '0;
        if (counts[i] != 0)
            for (int c = 0; c < 7; c++)
                m[c*13 +: 13] = 13'((sums[i][c] / counts[i]) % 8192);
        return m;
    endfunction

    function automatic int ref_latency(input int i);
        return (counts[i] == 0) ? 2 : 24;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 8; i++) begin
            counts[i] = $urandom_range(1, 1023);
            for (int c = 0; c < 7; c++)
                sums[i][c] = $urandom_range(0, 4194303);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_mean"}, 154'(new_centroid_out), 154'(0));
        chk({tag, "_cent"}, 154'(cent_num), 154'(0));
        chk({tag, "_div0"}, 154'(divide_by_0), 154'(0));
        chk({tag, "_valid"}, 154'(centroid_valid), 154'(0));
        chk({tag, "_busy"}, 154'(busy), 154'(0));
        chk({tag, "_done"}, 154'(done), 154'(0));
        chk({tag, "_sel"}, 154'(accum_sel), 154'(0));
    endtask

    // One pass: start, watch every emit against the model, optional mid-pass
    // start pulse or reset, optional start coinciding with done.
    task automatic run_pass(input string name, input int busy_start_at,
                            input int reset_at, input bit start_at_done);
        int cyc;
        int emits;
        int dones;
        int exp_cyc;
        bit finished;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; emits = 0; dones = 0; exp_cyc = 0; finished = 0;
        while (!finished && cyc < 300) begin
            start = (cyc == busy_start_at);
            if (cyc == reset_at) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs({name, "_midrst"});
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                chk({name, "_norestart"}, 154'(busy), 154'(0));
                $display("%s: reset applied at cycle %0d after %0d emits", name, cyc, emits);
                return;
            end
            chk({name, "_busy"}, 154'(busy), 154'(1));
            if (centroid_valid) begin
                if (emits < 8) begin
                    exp_cyc += ref_latency(emits);
                    chk({name, "_emit_cyc"}, 154'(cyc), 154'(exp_cyc));
                    chk({name, "_cent"}, 154'(cent_num), 154'(emits));
                    chk({name, "_mean"}, 154'(new_centroid_out), 154'(ref_mean(emits)));
                    chk({name, "_div0"}, 154'(divide_by_0), 154'(counts[emits] == 0));
                    $display("%s: cyc=%0d cent=%0d div0=%0b mean=%0h", name, cyc, cent_num,
                             divide_by_0, new_centroid_out);
                end
                emits++;
            end
            if (done) begin
                dones++;
                finished = 1;
                chk({name, "_nemits"}, 154'(emits), 154'(8));
                chk({name, "_done_cyc"}, 154'(cyc), 154'(exp_cyc + 1));
                $display("%s: done at cycle %0d", name, cyc);
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        chk({name, "_finished"}, 154'(finished), 154'(1));
        chk({name, "_ndones"}, 154'(dones), 154'(1));
        if (start_at_done) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk({name, "_start_at_done_ignored"}, 154'(busy), 154'(0));
        end else begin
            start = 1'b0;
            @(negedge clk);
            chk({name, "_idle"}, 154'(busy), 154'(0));
        end
        // Results must hold through IDLE
        repeat (2) @(negedge clk);
        chk({name, "_hold_mean"}, 154'(new_centroid_out), 154'(ref_mean(7)));
        chk({name, "_hold_cent"}, 154'(cent_num), 154'(7));
        chk({name, "_hold_done"}, 154'(done), 154'(0));
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        start  = 1'b0;
        rst_n  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            counts[i] = 0;
            for (int c = 0; c < 7; c++) sums[i][c] = 0;
        end
        #1;
        check_reset_outputs("por");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_no_start", 154'(busy), 154'(0));

        // Uniform pass: every coordinate 400/4 = 100, done at cycle 193
        for (int i = 0; i < 8; i++) begin
            counts[i] = 4;
            for (int c = 0; c < 7; c++) sums[i][c] = 400;
        end
        run_pass("uniform", -1, -1, 1'b0);

        // Zero count on centroid 3
        fill_random();
        counts[3] = 0;
        run_pass("zero_cnt", -1, -1, 1'b0);

        // Truncation corners
        fill_random();
        counts[0] = 3;
        counts[1] = 1;
        for (int c = 0; c < 7; c++) begin
            sums[0][c] = 1000;
            sums[1][c] = 4194303;
        end
        counts[7] = 1;
        sums[7][2] = 4194303;
        run_pass("trunc", -1, -1, 1'b0);

        // Start pulse during centroid 5 DIVIDE (cycles 122..143)
        fill_random();
        run_pass("busy_start", 130, -1, 1'b0);

        // Reset during centroid 2 DIVIDE (cycles 50..71), then a fresh pass
        fill_random();
        run_pass("mid_reset", -1, 60, 1'b0);
        run_pass("after_reset", -1, -1, 1'b0);

        // Start coinciding with done is ignored; then back-to-back identical passes
        fill_random();
        counts[6] = 0;
        run_pass("b2b_first", -1, -1, 1'b1);
        run_pass("b2b_second", -1, -1, 1'b0);

        // A couple of fully random passes, some small counts mixed in
        for (int p = 0; p < 2; p++) begin
            fill_random();
            counts[$urandom_range(0, 7)] = $urandom_range(0, 2);
            run_pass("random", -1, -1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
